// File: rtl/dmux_1by8_rr_dist.sv
// Round-robin 1-to-8 distributor with a one-entry registered output stage.
// Words go to the next enabled channel after the last one served; the held word waits for its channel.
module dmux_1by8_rr_dist #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   input  logic [7:0]   en_mask,
   output logic [7:0]   out_valid,
   output logic [W-1:0] out_data,
   input  logic [7:0]   out_ready,
   output logic [2:0]   cur_sel,
   output logic         busy
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [2:0]   r_ptr;
   logic [2:0]   r_sel;
   logic [W-1:0] r_data;
   logic [7:0]   r_out_valid;
   logic [2:0]   w_cand;
   logic [2:0]   w_idx;
   logic         w_cand_ok;
   logic         w_out_fire;
   logic         w_accept;

   // Scan from the highest circular offset down so the nearest enabled channel wins.
   always_comb begin
      w_cand_ok = 1'b0;
      w_cand    = 3'd0;
      w_idx     = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         w_idx = r_ptr + 3'(i);
         if (en_mask[w_idx]) begin
            w_cand_ok = 1'b1;
            w_cand    = w_idx;
         end else begin
            w_cand_ok = w_cand_ok;
         end
      end
   end

   assign w_out_fire = (r_state == ST_FULL) & out_ready[r_sel];
   assign in_ready   = ~rst & w_cand_ok & ((r_state == ST_EMPTY) | w_out_fire);
   assign w_accept   = in_valid & in_ready;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) w_state_nxt = ST_FULL;
            else          w_state_nxt = ST_EMPTY;
         end
         ST_FULL: begin
            if (w_out_fire & ~w_accept) w_state_nxt = ST_EMPTY;
            else                        w_state_nxt = ST_FULL;
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   // A delivery with no replacement clears out_valid but keeps data and select for observation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data      <= '0;
         r_sel       <= 3'd0;
         r_ptr       <= 3'd0;
         r_out_valid <= 8'h00;
      end else if (w_accept) begin
         r_data      <= in_data;
         r_sel       <= w_cand;
         r_ptr       <= w_cand + 3'd1;
         r_out_valid <= 8'h01 << w_cand;
      end else if (w_out_fire) begin
         r_out_valid <= 8'h00;
      end else begin
         r_out_valid <= r_out_valid;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_data;
   assign cur_sel   = r_sel;
   assign busy      = (r_state == ST_FULL);

endmodule

// File: doc/dmux_1by8_rr_dist.md
Name: dmux_1by8_rr_dist

Overview:
Round-robin distributor that sequences a 1-to-8 demultiplexer. It accepts a word stream over a valid/ready handshake and steers each word to exactly one of 8 output channels, rotating through the channels enabled in a mask. A one-entry registered output stage holds each word until the selected channel accepts it. The block sits between a single producer and eight consumer lanes and owns all select sequencing for the demux.

Parameters:
W, 8, data word width in bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  producer has a word on in_data
in_data  input  W  producer word
in_ready  output  1  block accepts in_data this cycle
en_mask  input  8  bit k=1 makes channel k eligible for selection
out_valid  output  8  one-hot; bit k=1 means out_data is offered to channel k
out_data  output  W  held word, shared by all channels
out_ready  input  8  bit k=1 means channel k accepts this cycle
cur_sel  output  3  channel index of the held word (valid only while busy)
busy  output  1  output register holds an undelivered word

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst); all state changes on the rising clk edge.
- Reset: out_valid=8'h00, out_data=0, cur_sel=0, busy=0, and internal pointer ptr=0. in_ready is combinational and reads 0 while rst=1.
- States:
  - EMPTY (busy=0).
  - FULL (busy=1, out_valid=one-hot(cur_sel)).
- Delivery: out_fire = busy & out_ready[cur_sel]. Bits of out_ready for other channels are ignored.
- Candidate channel c = first k in circular order ptr, ptr+1, ..., ptr+7 (mod 8) with en_mask[k]=1. If en_mask=0, there is no candidate.
- in_ready = (candidate exists) & (~busy | out_fire). Accept = in_valid & in_ready.
- On Accept:
  - out_data<=in_data, cur_sel<=c, busy<=1.
  - ptr<=(c+1) mod 8, wrapping 7->0.
- On out_fire without Accept: busy<=0, out_valid<=0. out_data and cur_sel hold their last values.
- Simultaneous out_fire and Accept: new word loaded with no bubble; busy stays 1 and out_valid moves to the new one-hot. Sustained throughput is 1 word/cycle.
- Latency: a word accepted at edge N is presented (out_valid high) in the cycle after edge N. It stays presented, stable, until out_fire.
- Transitions: EMPTY->FULL on Accept; FULL->EMPTY on out_fire & ~Accept; FULL->FULL on ~out_fire, or on out_fire & Accept.
- Back-pressure: while FULL and ~out_fire, in_ready=0. out_data and cur_sel do not change.
- Mask changes: affect only future selections. A held word is delivered to its latched cur_sel even if en_mask[cur_sel] drops to 0. ptr is not altered by mask changes.
- Single enabled channel: every word goes to that channel; ptr advances to that index+1.
- Reset mid-operation: the held word is discarded, out_valid drops to 0 at that edge, and ptr returns to 0.
- out_valid is never multi-hot. out_valid=0 whenever busy=0.

Test Plan:
1. Reset, then en_mask=8'hFF, out_ready=8'hFF, feed 0x10..0x19 back-to-back. Required: channels 0,1,...,7,0,1 in order, out_valid=01,02,...,80,01,02; in_ready=1 every cycle; no bubbles.
2. en_mask=8'b1010_0100, out_ready=8'hFF, feed 5 words. Required: cur_sel sequence 2,5,7,2,5 (wrap skips disabled channels).
3. en_mask=8'hFF, out_ready=0, send 0xA5. Required: cur_sel=0, out_valid=01, held for 4 cycles; in_ready=0 and a pending 0x3C not taken. Then raise out_ready[0]: 0xA5 delivered and 0x3C loaded the same edge to channel 1 (out_valid=02).
4. Hold 0x77 on channel 3 with out_ready[3]=0, then set en_mask=8'h01. Required: 0x77 still delivered on channel 3 when out_ready[3]=1; next word goes to channel 0.
5. en_mask=0 with in_valid=1 for 5 cycles. Required: in_ready=0, out_valid=0. Set en_mask=8'h10: the next word goes to channel 4.
6. Hold a word on channel 6, assert rst for 1 cycle. Required: out_valid=0 and busy=0 after that edge. With en_mask=8'hFF, the next word goes to channel 0.
